csr_ctrl: RTL and testbench

Sequencing initiator for the CSR register file. It sits between execute and the CSR file and accepts one SYSTEM-opcode instruction at a time. For each instruction it drives the register file's read, write and trap ports over a fixed 3-cycle sequence. It returns the old CSR value for rd, and for traps and mret it returns a PC redirect.

---
 rtl/csr_ctrl_pkg.sv | 63 ++++++
 rtl/csr_decode.sv | 41 ++++
 rtl/csr_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_csr_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg
// Shared definitions for the CSR sequencing initiator and its decoder:
// widths, SYSTEM opcode / funct3 encodings, privileged immediates, trap
// encodings understood by the CSR file, the decoded-op struct and the
// read-modify-write helper.
package csr_ctrl_pkg;

    localparam int INSTR_MEM_WIDTH = 32;
    localparam int CSR_ADDR_WIDTH  = 12;
    localparam int CSR_WIDTH       = 32;

    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [CSR_ADDR_WIDTH-1:0] SYS_ECALL = 12'h000;
    localparam logic [CSR_ADDR_WIDTH-1:0] SYS_MRET  = 12'h302;

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC = 12'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC  = 12'h341;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ECALL   = 2'b01;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
    localparam logic [1:0] TRAP_MRET    = 2'b11;

    typedef enum logic [2:0] {
        OP_CSRRW,
        OP_CSRRS,
        OP_CSRRC,
        OP_ECALL,
        OP_MRET,
        OP_ILLEGAL
    } op_e;

    typedef struct packed {
        op_e                       op;
        logic                      use_imm;   // operand is zext(instr[19:15])
        logic [4:0]                rs1_idx;   // rs1 index or immediate
        logic [4:0]                rd_idx;
        logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    } decode_t;

    // New CSR value for the read-modify-write ops.
    function automatic logic [CSR_WIDTH-1:0] csr_update(
        input op_e                  op,
        input logic [CSR_WIDTH-1:0] old_val,
        input logic [CSR_WIDTH-1:0] operand
    );
        case (op)
            OP_CSRRS: csr_update = old_val | operand;
            OP_CSRRC: csr_update = old_val & ~operand;
            default:  csr_update = operand;
        endcase
    endfunction

endpackage

// File: rtl/csr_decode.sv
// csr_decode
// Combinational classifier for a raw instruction offered to csr_ctrl.
// Ports:
//   instr  in  32         raw instruction
//   dec    out decode_t   op class, operand select, rs1/imm, rd, CSR address
module csr_decode
    import csr_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    always_comb begin
        dec          = '0;
        dec.op       = OP_ILLEGAL;
        dec.use_imm  = instr[14];
        dec.rs1_idx  = instr[19:15];
        dec.rd_idx   = instr[11:7];
        dec.csr_addr = instr[31:20];

        if (instr[6:0] == OPCODE_SYSTEM) begin
            case (instr[14:12])
                F3_CSRRW, F3_CSRRWI: dec.op = OP_CSRRW;
                F3_CSRRS, F3_CSRRSI: dec.op = OP_CSRRS;
                F3_CSRRC, F3_CSRRCI: dec.op = OP_CSRRC;
                F3_PRIV: begin
                    // ebreak and every other privileged immediate is illegal
                    if (instr[31:20] == SYS_ECALL) begin
                        dec.op = OP_ECALL;
                    end else if (instr[31:20] == SYS_MRET) begin
                        dec.op = OP_MRET;
                    end else begin
                        dec.op = OP_ILLEGAL;
                    end
                end
                default: dec.op = OP_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl
// Sequencing initiator between execute and the CSR register file. Accepts
// one SYSTEM instruction at a time and walks a fixed 3-cycle sequence:
//   CSR op : IDLE -> READ -> WRITE -> DONE
//   ecall/illegal : IDLE -> TRAP -> VEC -> DONE
//   mret   : IDLE -> READ -> TRAP -> DONE
// All outputs are registered; each is computed for the state being entered.
// Ports:
//   clk, rst (sync, active-high)
//   req_valid/req_ready, instr, rs1_data, pc_in   request from execute
//   resp_valid, rd_we, rd_data                    writeback (one-cycle pulse)
//   redirect_valid, redirect_pc                   fetch redirect
//   csr_we, csr_trap, csr_pc, csr_write_addr,
//   csr_write_data, csr_read_addr                 to the CSR file
//   csr_read_data                                 combinational read return
module csr_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                instr,
    input  logic [CSR_WIDTH-1:0]       rs1_data,
    input  logic [INSTR_MEM_WIDTH-1:0] pc_in,
    output logic                       resp_valid,
    output logic                       rd_we,
    output logic [CSR_WIDTH-1:0]       rd_data,
    output logic                       redirect_valid,
    output logic [INSTR_MEM_WIDTH-1:0] redirect_pc,
    output logic                       csr_we,
    output logic [1:0]                 csr_trap,
    output logic [INSTR_MEM_WIDTH-1:0] csr_pc,
    output logic [CSR_ADDR_WIDTH-1:0]  csr_write_addr,
    output logic [CSR_WIDTH-1:0]       csr_write_data,
    output logic [CSR_ADDR_WIDTH-1:0]  csr_read_addr,
    input  logic [CSR_WIDTH-1:0]       csr_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_VEC,
        S_DONE
    } state_e;

    decode_t in_dec;

    csr_decode u_decode (
        .instr (instr),
        .dec   (in_dec)
    );

    state_e                     state_q, state_d;
    decode_t                    dec_q, dec_d;
    logic [CSR_WIDTH-1:0]       operand_q, operand_d;
    logic [INSTR_MEM_WIDTH-1:0] pc_q, pc_d;
    // Old CSR value for CSR ops; redirect target for traps and mret.
    logic [CSR_WIDTH-1:0]       old_q, old_d;

    logic                       req_ready_q, req_ready_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       rd_we_q, rd_we_d;
    logic [CSR_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                       redirect_valid_q, redirect_valid_d;
    logic [INSTR_MEM_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                       csr_we_q, csr_we_d;
    logic [1:0]                 csr_trap_q, csr_trap_d;
    logic [INSTR_MEM_WIDTH-1:0] csr_pc_q, csr_pc_d;
    logic [CSR_ADDR_WIDTH-1:0]  csr_write_addr_q, csr_write_addr_d;
    logic [CSR_WIDTH-1:0]       csr_write_data_q, csr_write_data_d;
    logic [CSR_ADDR_WIDTH-1:0]  csr_read_addr_q, csr_read_addr_d;

    logic                       accept;
    logic                       set_clear_nop;

    assign accept = req_valid && req_ready_q;

    // csrrs/csrrc (and immediate forms) with a zero source never write.
    assign set_clear_nop = (dec_q.op == OP_CSRRS || dec_q.op == OP_CSRRC) &&
                           (dec_q.rs1_idx == 5'd0);

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        old_d     = old_q;

        // Every output is a per-state pulse; default back to zero.
        resp_valid_d     = 1'b0;
        rd_we_d          = 1'b0;
        rd_data_d        = '0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        csr_we_d         = 1'b0;
        csr_trap_d       = TRAP_NONE;
        csr_pc_d         = '0;
        csr_write_addr_d = '0;
        csr_write_data_d = '0;
        csr_read_addr_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dec_d     = in_dec;
                    operand_d = in_dec.use_imm ? {{(CSR_WIDTH-5){1'b0}}, in_dec.rs1_idx}
                                               : rs1_data;
                    pc_d      = pc_in;
                    case (in_dec.op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                            state_d         = S_READ;
                            csr_read_addr_d = in_dec.csr_addr;
                        end
                        OP_MRET: begin
                            state_d         = S_READ;
                            csr_read_addr_d = CSR_MEPC;
                        end
                        OP_ECALL: begin
                            state_d    = S_TRAP;
                            csr_trap_d = TRAP_ECALL;
                            csr_pc_d   = pc_in;
                        end
                        default: begin
                            state_d    = S_TRAP;
                            csr_trap_d = TRAP_ILLEGAL;
                            csr_pc_d   = pc_in;
                        end
                    endcase
                end
            end
            S_READ: begin
                old_d = csr_read_data;
                if (dec_q.op == OP_MRET) begin
                    state_d    = S_TRAP;
                    csr_trap_d = TRAP_MRET;
                    csr_pc_d   = pc_q;
                end else begin
                    state_d          = S_WRITE;
                    csr_we_d         = !set_clear_nop;
                    csr_write_addr_d = dec_q.csr_addr;
                    csr_write_data_d = csr_update(dec_q.op, csr_read_data, operand_q);
                end
            end
            S_WRITE: begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                rd_we_d      = (dec_q.rd_idx != 5'd0);
                rd_data_d    = old_q;
            end
            S_TRAP: begin
                if (dec_q.op == OP_MRET) begin
                    state_d          = S_DONE;
                    resp_valid_d     = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = old_q[INSTR_MEM_WIDTH-1:0];
                end else begin
                    state_d         = S_VEC;
                    csr_read_addr_d = CSR_MTVEC;
                end
            end
            S_VEC: begin
                old_d            = csr_read_data;
                state_d          = S_DONE;
                resp_valid_d     = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = csr_read_data[INSTR_MEM_WIDTH-1:0];
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            dec_q            <= '0;
            operand_q        <= '0;
            pc_q             <= '0;
            old_q            <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            rd_we_q          <= 1'b0;
            rd_data_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            csr_we_q         <= 1'b0;
            csr_trap_q       <= TRAP_NONE;
            csr_pc_q         <= '0;
            csr_write_addr_q <= '0;
            csr_write_data_q <= '0;
            csr_read_addr_q  <= '0;
        end else begin
            state_q          <= state_d;
            dec_q            <= dec_d;
            operand_q        <= operand_d;
            pc_q             <= pc_d;
            old_q            <= old_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            rd_we_q          <= rd_we_d;
            rd_data_q        <= rd_data_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            csr_we_q         <= csr_we_d;
            csr_trap_q       <= csr_trap_d;
            csr_pc_q         <= csr_pc_d;
            csr_write_addr_q <= csr_write_addr_d;
            csr_write_data_q <= csr_write_data_d;
            csr_read_addr_q  <= csr_read_addr_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign rd_we          = rd_we_q;
    assign rd_data        = rd_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign csr_we         = csr_we_q;
    assign csr_trap       = csr_trap_q;
    assign csr_pc         = csr_pc_q;
    assign csr_write_addr = csr_write_addr_q;
    assign csr_write_data = csr_write_data_q;
    assign csr_read_addr  = csr_read_addr_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl with a small behavioural CSR file
// (mstatus, mtvec, mscratch, mepc, mcause; other addresses read 0).
module tb_csr_ctrl;
    import csr_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] pc_in = '0;
    logic        resp_valid, rd_we, redirect_valid, csr_we;
    logic [31:0] rd_data, redirect_pc, csr_pc, csr_write_data, csr_read_data;
    logic [1:0]  csr_trap;
    logic [11:0] csr_write_addr, csr_read_addr;

    always #5 clk = ~clk;

    csr_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .instr          (instr),
        .rs1_data       (rs1_data),
        .pc_in          (pc_in),
        .resp_valid     (resp_valid),
        .rd_we          (rd_we),
        .rd_data        (rd_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_we         (csr_we),
        .csr_trap       (csr_trap),
        .csr_pc         (csr_pc),
        .csr_write_addr (csr_write_addr),
        .csr_write_data (csr_write_data),
        .csr_read_addr  (csr_read_addr),
        .csr_read_data  (csr_read_data)
    );

    // ---------------- CSR file model ----------------
    logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mscratch = '0, m_mepc = '0, m_mcause = '0;
    logic        preset_en = 1'b0;
    logic [11:0] preset_addr = '0;
    logic [31:0] preset_val = '0;
    int          we_cnt = 0, trap_cnt = 0, coll_cnt = 0;
    logic [1:0]  last_trap = 2'b00;

    logic        m_we;
    logic [11:0] m_wa;
    logic [31:0] m_wd;

    always_comb begin
        case (csr_read_addr)
            12'h300: csr_read_data = m_mstatus;
            12'h305: csr_read_data = m_mtvec;
            12'h340: csr_read_data = m_mscratch;
            12'h341: csr_read_data = m_mepc;
            12'h342: csr_read_data = m_mcause;
            default: csr_read_data = 32'h0;
        endcase
    end

    always_comb begin
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        if (preset_en) begin
            m_we = 1'b1; m_wa = preset_addr; m_wd = preset_val;
        end else if (csr_we) begin
            m_we = 1'b1; m_wa = csr_write_addr; m_wd = csr_write_data;
        end
    end

    always @(posedge clk) begin
        if (csr_we) we_cnt <= we_cnt + 1;
        if (csr_trap != 2'b00) begin
            trap_cnt  <= trap_cnt + 1;
            last_trap <= csr_trap;
        end
        if (csr_we && csr_trap != 2'b00) coll_cnt <= coll_cnt + 1;
        if (m_we) begin
            case (m_wa)
                12'h300: m_mstatus  <= m_wd;
                12'h305: m_mtvec    <= m_wd;
                12'h340: m_mscratch <= m_wd;
                12'h341: m_mepc     <= m_wd;
                12'h342: m_mcause   <= m_wd;
                default: ;
            endcase
        end else if (csr_trap == 2'b01) begin
            m_mepc   <= csr_pc;
            m_mcause <= 32'd11;
        end else if (csr_trap == 2'b10) begin
            m_mepc   <= csr_pc;
            m_mcause <= 32'd2;
        end else if (csr_trap == 2'b11) begin
            m_mstatus[31] <= m_mstatus[30];
            m_mstatus[30] <= 1'b1;
        end
    end

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: mread = m_mstatus;
            12'h305: mread = m_mtvec;
            12'h340: mread = m_mscratch;
            12'h341: mread = m_mepc;
            12'h342: mread = m_mcause;
            default: mread = 32'h0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        enc = {csr, rs1, f3, rd, 7'b1110011};
    endfunction

    task automatic preset(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        preset_en = 1'b1; preset_addr = a; preset_val = v;
        @(posedge clk);
        #1 preset_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [11:0] pa1; logic [31:0] pv1;
        logic [11:0] pa2; logic [31:0] pv2;
        logic        rd_we;
        logic [31:0] rd_data;
        logic        redir;
        logic [31:0] redir_pc;
        int          n_we;
        logic [1:0]  trap;
        logic [11:0] ca1; logic [31:0] cv1;
        logic [11:0] ca2; logic [31:0] cv2;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int lat;
        int we0, tr0;
        logic s_rd_we, s_redir;
        logic [31:0] s_rd_data, s_redir_pc;
        logic [7:0] ready_bits, resp_bits;

        //        instr                               rs1           pc     preset1              preset2              rd_we rd_data      redir redir_pc     n_we trap   check1                 check2
        vecs[0]  = '{enc(12'h305, 5'd6, 3'b001, 5'd5), 32'h200,      32'h0, 12'h305, 32'h100, 12'h305, 32'h100, 1'b1, 32'h100,     1'b0, 32'h0,       1, 2'b00, 12'h305, 32'h200,      12'h305, 32'h200};
        vecs[1]  = '{enc(12'h300, 5'd8, 3'b010, 5'd7), 32'hF0,       32'h0, 12'h300, 32'h0F,  12'h300, 32'h0F,  1'b1, 32'h0F,      1'b0, 32'h0,       1, 2'b00, 12'h300, 32'hFF,       12'h300, 32'hFF};
        vecs[2]  = '{enc(12'h300, 5'd9, 3'b011, 5'd7), 32'h0F,       32'h0, 12'h300, 32'hFF,  12'h300, 32'hFF,  1'b1, 32'hFF,      1'b0, 32'h0,       1, 2'b00, 12'h300, 32'hF0,       12'h300, 32'hF0};
        vecs[3]  = '{enc(12'h300, 5'd0, 3'b010, 5'd1), 32'hFFFF,     32'h0, 12'h300, 32'hF0,  12'h300, 32'hF0,  1'b1, 32'hF0,      1'b0, 32'h0,       0, 2'b00, 12'h300, 32'hF0,       12'h300, 32'hF0};
        vecs[4]  = '{enc(12'h340, 5'd21, 3'b101, 5'd2), 32'hFFFFFFFF, 32'h0, 12'h340, 32'hDEAD, 12'h340, 32'hDEAD, 1'b1, 32'hDEAD, 1'b0, 32'h0,       1, 2'b00, 12'h340, 32'h15,       12'h340, 32'h15};
        vecs[5]  = '{enc(12'h340, 5'd0, 3'b110, 5'd3), 32'hFFFFFFFF, 32'h0, 12'h340, 32'h1234, 12'h340, 32'h1234, 1'b1, 32'h1234, 1'b0, 32'h0,       0, 2'b00, 12'h340, 32'h1234,     12'h340, 32'h1234};
        vecs[6]  = '{enc(12'h340, 5'd3, 3'b111, 5'd4), 32'h0,        32'h0, 12'h340, 32'hFF,  12'h340, 32'hFF,  1'b1, 32'hFF,      1'b0, 32'h0,       1, 2'b00, 12'h340, 32'hFC,       12'h340, 32'hFC};
        vecs[7]  = '{enc(12'h340, 5'd6, 3'b001, 5'd0), 32'hABCD,     32'h0, 12'h340, 32'h5,   12'h340, 32'h5,   1'b0, 32'h5,       1'b0, 32'h0,       1, 2'b00, 12'h340, 32'hABCD,     12'h340, 32'hABCD};
        vecs[8]  = '{enc(12'h7C0, 5'd6, 3'b001, 5'd5), 32'h99,       32'h0, 12'h7C0, 32'h0,   12'h7C0, 32'h0,   1'b1, 32'h0,       1'b0, 32'h0,       1, 2'b00, 12'h7C0, 32'h0,        12'h7C0, 32'h0};
        vecs[9]  = '{32'h00000073,                     32'h0,        32'h44, 12'h305, 32'h80, 12'h342, 32'h0,   1'b0, 32'h0,       1'b1, 32'h80,      0, 2'b01, 12'h341, 32'h44,       12'h342, 32'd11};
        vecs[10] = '{32'h00000033,                     32'h0,        32'h10, 12'h305, 32'h200, 12'h342, 32'h0,  1'b0, 32'h0,       1'b1, 32'h200,     0, 2'b10, 12'h341, 32'h10,       12'h342, 32'd2};
        vecs[11] = '{32'h00100073,                     32'h0,        32'h20, 12'h305, 32'h300, 12'h342, 32'h0,  1'b0, 32'h0,       1'b1, 32'h300,     0, 2'b10, 12'h341, 32'h20,       12'h342, 32'd2};
        vecs[12] = '{enc(12'h305, 5'd1, 3'b100, 5'd2), 32'h1,        32'h24, 12'h305, 32'h400, 12'h342, 32'h0,  1'b0, 32'h0,       1'b1, 32'h400,     0, 2'b10, 12'h305, 32'h400,      12'h342, 32'd2};
        vecs[13] = '{32'h30200073,                     32'h0,        32'h60, 12'h341, 32'h48, 12'h300, 32'h40000000, 1'b0, 32'h0,  1'b1, 32'h48,      0, 2'b11, 12'h300, 32'hC0000000, 12'h341, 32'h48};
        vecs[14] = '{32'h30200073,                     32'h0,        32'h64, 12'h341, 32'h1000, 12'h300, 32'h0, 1'b0, 32'h0,       1'b1, 32'h1000,    0, 2'b11, 12'h300, 32'h40000000, 12'h341, 32'h1000};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_pulses", {26'h0, resp_valid, rd_we, redirect_valid, csr_we, csr_trap}, 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_csr_pc", csr_pc, 32'h0);
        chk("reset_addrs", {8'h0, csr_write_addr, csr_read_addr}, 32'h0);
        chk("reset_wdata", csr_write_data, 32'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 15; i++) begin
            preset(vecs[i].pa1, vecs[i].pv1);
            preset(vecs[i].pa2, vecs[i].pv2);
            we0 = we_cnt;
            tr0 = trap_cnt;
            @(negedge clk);
            instr = vecs[i].instr; rs1_data = vecs[i].rs1; pc_in = vecs[i].pc;
            req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            lat = 99;
            s_rd_we = 1'b0; s_redir = 1'b0; s_rd_data = '0; s_redir_pc = '0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (resp_valid) begin
                    lat = c;
                    s_rd_we = rd_we; s_rd_data = rd_data;
                    s_redir = redirect_valid; s_redir_pc = redirect_pc;
                    break;
                end
            end
            $display("vec %0d instr=0x%08h lat=%0d rd_we=%0d rd_data=0x%08h redir=%0d redir_pc=0x%08h",
                     i, vecs[i].instr, lat, s_rd_we, s_rd_data, s_redir, s_redir_pc);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_rd_we", i), {31'h0, s_rd_we}, {31'h0, vecs[i].rd_we});
            chk($sformatf("v%0d_rd_data", i), s_rd_data, vecs[i].rd_data);
            chk($sformatf("v%0d_redirect_valid", i), {31'h0, s_redir}, {31'h0, vecs[i].redir});
            chk($sformatf("v%0d_redirect_pc", i), s_redir_pc, vecs[i].redir_pc);
            chk($sformatf("v%0d_we_pulses", i), we_cnt - we0, vecs[i].n_we);
            chk($sformatf("v%0d_trap_pulses", i), trap_cnt - tr0, (vecs[i].trap != 2'b00) ? 1 : 0);
            if (vecs[i].trap != 2'b00)
                chk($sformatf("v%0d_trap_code", i), {30'h0, last_trap}, {30'h0, vecs[i].trap});
            chk($sformatf("v%0d_csr_a", i), mread(vecs[i].ca1), vecs[i].cv1);
            chk($sformatf("v%0d_csr_b", i), mread(vecs[i].ca2), vecs[i].cv2);
            @(negedge clk);
            chk($sformatf("v%0d_resp_one_cycle", i), {30'h0, resp_valid, req_ready}, 32'h1);
        end

        // ---------------- reset during WRITE ----------------
        preset(12'h305, 32'h100);
        @(negedge clk);
        instr = enc(12'h305, 5'd6, 3'b001, 5'd5); rs1_data = 32'h777; pc_in = 32'h0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);                 // READ
        @(negedge clk);                 // WRITE
        chk("rstmid_we_in_write", {31'h0, csr_we}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid_write_kept", m_mtvec, 32'h777);
        we0 = we_cnt; tr0 = trap_cnt; lat = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) lat++;
        end
        $display("reset-mid-op: extra resp=%0d extra we=%0d extra trap=%0d", lat, we_cnt - we0, trap_cnt - tr0);
        chk("rstmid_quiet", lat + (we_cnt - we0) + (trap_cnt - tr0), 0);

        // ---------------- back-to-back requests ----------------
        preset(12'h300, 32'h3C);
        @(negedge clk);
        instr = enc(12'h300, 5'd0, 3'b010, 5'd1); rs1_data = 32'h0; pc_in = 32'h0;
        req_valid = 1'b1;
        ready_bits = '0; resp_bits = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ready_bits[k-1] = req_ready;
            resp_bits[k-1]  = resp_valid;
            if (k == 8) req_valid = 1'b0;
        end
        $display("back-to-back: ready=%08b resp=%08b", ready_bits, resp_bits);
        chk("b2b_ready_pattern", {24'h0, ready_bits}, 32'h88);
        chk("b2b_resp_pattern", {24'h0, resp_bits}, 32'h44);

        chk("we_trap_exclusive", coll_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
